sdram_port_arbiter: RTL

Round-robin scheduler for the four-port SDRAM controller. It owns the per-port address and length registers for two write FIFOs and two read FIFOs. It decides which port gets the next burst and drives the burst request (`mADDR`, `mLENGTH`, `mWR`/`mRD`, masks) into the command sequencer. It replaces fixed WR1>WR2>RD1>RD2 priority so that no port starves under sustained load.

---
 rtl/sdram_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin burst scheduler for the four-port SDRAM controller (WR1, WR2, RD1, RD2).
// Owns per-port address/length registers and issues one burst request at a time.
module sdram_port_arbiter #(
  parameter int unsigned ASIZE   = 22,
  parameter int unsigned LSIZE   = 9,
  parameter int unsigned DEF_LEN = 256
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 SEQ_IDLE,
  input  logic [4*LSIZE-1:0]   P_LEVEL,
  input  logic [4*LSIZE-1:0]   P_LENGTH,
  input  logic [4*ASIZE-1:0]   P_BASE,
  input  logic [4*ASIZE-1:0]   P_MAX,
  input  logic [3:0]           P_LOAD,
  input  logic                 mWR_DONE,
  input  logic                 mRD_DONE,
  output logic [ASIZE-1:0]     mADDR,
  output logic [LSIZE-1:0]     mLENGTH,
  output logic                 mWR,
  output logic                 mRD,
  output logic [1:0]           WR_MASK,
  output logic [1:0]           RD_MASK,
  output logic [1:0]           GRANT_PORT
);

  typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [ASIZE-1:0] r_addr [4];
  logic [LSIZE-1:0] r_len  [4];
  logic [1:0]       r_ptr;
  logic             r_reload;

  logic [LSIZE-1:0] w_level  [4];
  logic [LSIZE-1:0] w_length [4];
  logic [ASIZE-1:0] w_base   [4];
  logic [ASIZE-1:0] w_max    [4];
  logic [3:0]       w_elig;

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    assign w_level[gi]  = P_LEVEL[LSIZE*gi +: LSIZE];
    assign w_length[gi] = P_LENGTH[LSIZE*gi +: LSIZE];
    assign w_base[gi]   = P_BASE[ASIZE*gi +: ASIZE];
    assign w_max[gi]    = P_MAX[ASIZE*gi +: ASIZE];
    if (gi < 2) begin : g_wr
      // Write port needs a full burst buffered; zero length never qualifies.
      assign w_elig[gi] = (w_level[gi] >= r_len[gi]) && (r_len[gi] != '0);
    end else begin : g_rd
      assign w_elig[gi] = (w_level[gi] < r_len[gi]);
    end
  end

  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int j = 0; j < 4; j++) begin
      w_idx = r_ptr + 2'(j);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  logic w_start;
  logic w_done;

  assign w_start = (r_state == StIdle) && SEQ_IDLE && (P_LOAD == 4'b0000) && w_found;
  assign w_done  = (r_state == StBusy) && (mRD ? mRD_DONE : mWR_DONE);

  // Next address for the granted port; comparison and sum wrap modulo 2^ASIZE.
  logic [ASIZE-1:0] w_len_ext;
  logic [ASIZE-1:0] w_limit;
  logic [ASIZE-1:0] w_next_addr;

  assign w_len_ext   = {{(ASIZE-LSIZE){1'b0}}, r_len[GRANT_PORT]};
  assign w_limit     = w_max[GRANT_PORT] - w_len_ext;
  assign w_next_addr = (r_addr[GRANT_PORT] < w_limit) ? (r_addr[GRANT_PORT] + w_len_ext)
                                                       : w_base[GRANT_PORT];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start) w_state_d = StBusy;
      StBusy:  if (w_done)  w_state_d = StGap;
      StGap:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // A reload of the granted port at any point during the burst cancels the advance.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_reload <= 1'b0;
    end else if (w_start) begin
      r_reload <= 1'b0;
    end else if ((r_state == StBusy) && P_LOAD[GRANT_PORT]) begin
      r_reload <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) begin
        r_addr[i] <= '0;
        r_len[i]  <= LSIZE'(DEF_LEN);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (P_LOAD[i]) begin
          r_addr[i] <= w_base[i];
          r_len[i]  <= w_length[i];
        end else if (w_done && !r_reload && (GRANT_PORT == 2'(i))) begin
          r_addr[i] <= w_next_addr;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mADDR      <= '0;
      mLENGTH    <= '0;
      mWR        <= 1'b0;
      mRD        <= 1'b0;
      WR_MASK    <= 2'b00;
      RD_MASK    <= 2'b00;
      GRANT_PORT <= 2'd0;
      r_ptr      <= 2'd0;
    end else if (w_start) begin
      mADDR      <= r_addr[w_pick];
      mLENGTH    <= r_len[w_pick];
      GRANT_PORT <= w_pick;
      r_ptr      <= w_pick + 2'd1;
      mWR        <= ~w_pick[1];
      mRD        <= w_pick[1];
      WR_MASK    <= w_pick[1] ? 2'b00 : (w_pick[0] ? 2'b10 : 2'b01);
      RD_MASK    <= w_pick[1] ? (w_pick[0] ? 2'b10 : 2'b01) : 2'b00;
    end else if (w_done) begin
      mWR     <= 1'b0;
      mRD     <= 1'b0;
      WR_MASK <= 2'b00;
      RD_MASK <= 2'b00;
    end
  end

endmodule
